// File: rtl/tdc_sample_averager.sv
// tdc_sample_averager: accumulates 2^log2n TDC codes and presents their
// truncated mean with a valid/ready handshake. Optional per-run min/max
// tracking is compiled in only when TDC_AVG_MINMAX_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; incoming samples are ignored
// S_ACCUM | summing valid samples until N have been accepted
// S_DONE  | avg/avg_valid held until consumer handshake; samples dropped
module tdc_sample_averager #(
    parameter int CODE_W    = 8,
    parameter int MAX_LOG2N = 7
) (
    input  logic              clk,
    input  logic              rst_n,      // active-high synchronous reset
    input  logic              start,
    input  logic [2:0]        log2n,
    input  logic [CODE_W-1:0] tdc_code,
    input  logic              tdc_valid,
    output logic [CODE_W-1:0] avg,
    output logic              avg_valid,
    input  logic              avg_ready,
    output logic              busy,
    output logic              overrun,
    output logic [CODE_W-1:0] min_code,
    output logic [CODE_W-1:0] max_code
);

    localparam int AW = CODE_W + MAX_LOG2N;
    localparam int CW = MAX_LOG2N + 1;
    localparam int SW = (MAX_LOG2N < 1) ? 1 : $clog2(MAX_LOG2N + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]     shift_q, shift_d;
    logic [CODE_W-1:0] avg_q, avg_d;
    logic              overrun_q, overrun_d;

    logic [SW-1:0]     shift_sel;
    logic [AW-1:0]     acc_sum;
    logic              cnt_last;

    // Clamp the requested sample-count exponent to what the accumulator can hold.
    always_comb begin
        shift_sel = SW'(log2n);
        if (int'(log2n) > MAX_LOG2N) begin
            shift_sel = SW'(MAX_LOG2N);
        end
    end

    assign acc_sum  = acc_q + AW'(tdc_code);
    assign cnt_last = (cnt_q == ((CW'(1) << shift_q) - CW'(1)));

    // Next-state and datapath updates; every target defaults to hold.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        avg_d     = avg_q;
        overrun_d = overrun_q;
        case (state_q)
            S_IDLE: begin
                // A sample coinciding with start belongs to no run and is dropped.
                if (start) begin
                    shift_d   = shift_sel;
                    acc_d     = '0;
                    cnt_d     = '0;
                    overrun_d = 1'b0;
                    state_d   = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (tdc_valid) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_last) begin
                        avg_d   = CODE_W'(acc_sum >> shift_q);
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (tdc_valid) begin
                    overrun_d = 1'b1;
                end
                if (avg_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            shift_q   <= '0;
            avg_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            avg_q     <= avg_d;
            overrun_q <= overrun_d;
        end
    end

    assign avg       = avg_q;
    assign avg_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign overrun   = overrun_q;

`ifdef TDC_AVG_MINMAX_EN
    logic [CODE_W-1:0] min_q, min_d, max_q, max_d;
    logic              mm_init, mm_sample;

    assign mm_init   = (state_q == S_IDLE) && start;
    assign mm_sample = (state_q == S_ACCUM) && tdc_valid;

    // Extremes seeded on start so the first sample always replaces both.
    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (mm_init) begin
            min_d = '1;
            max_d = '0;
        end else if (mm_sample) begin
            if (tdc_code < min_q) min_d = tdc_code;
            if (tdc_code > max_q) max_d = tdc_code;
        end
    end

    // Min/max registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            min_q <= '0;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign min_code = min_q;
    assign max_code = max_q;
`else
    assign min_code = '0;
    assign max_code = '0;
`endif

endmodule
